rst_seq: RTL



---
 rtl/rst_seq_if.sv | 25 ++
 rtl/rst_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rst_seq_if.sv
// Lock/button inputs and reset outputs of the core reset sequencer.
// The slave side is the sequencer; the master side is whoever drives it.
interface rst_seq_if;
    logic pll_lock;
    logic btn_n;
    logic rst_core;
    logic run;
    logic btn_evt;

    modport master (
        output pll_lock,
        output btn_n,
        input  rst_core,
        input  run,
        input  btn_evt
    );

    modport slave (
        input  pll_lock,
        input  btn_n,
        output rst_core,
        output run,
        output btn_evt
    );
endinterface

// File: rtl/rst_seq.sv
// Core reset sequencer: qualifies PLL lock and a debounced push button.
// Produces the stretched core reset, the run flag and a one-cycle press event.
//
// state       | meaning
// ------------+-------------------------------------------------------
// S_RESET     | first cycle after rst; always moves on to S_WAIT_LOCK
// S_WAIT_LOCK | core held in reset until the synchronized lock is seen
// S_HOLD      | lock present, stretching rst_core for HOLD_CYCLES
// S_RUN       | core released; lock loss or a press re-asserts reset
module rst_seq #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] DEB_CYCLES  = 16'd50000,
    parameter logic [7:0]  HOLD_CYCLES = 8'd16
) (
    input logic     clk,
    input logic     rst,
    rst_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_RESET     = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_HOLD      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
    logic [15:0]            deb_cnt_q, deb_cnt_d;
    logic                   btn_st_q, btn_st_d;
    logic                   btn_st_dly_q, btn_st_dly_d;
    logic                   btn_evt_q, btn_evt_d;
    logic [7:0]             hold_cnt_q, hold_cnt_d;
    state_t                 state_q, state_d;
    logic                   rst_core_q, rst_core_d;
    logic                   run_q, run_d;

    logic lock_s;
    logic btn_s;
    logic press_acc;

    assign lock_s = lock_sync_q[SYNC_STAGES-1];
    assign btn_s  = btn_sync_q[SYNC_STAGES-1];

    always_comb begin
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], bus.pll_lock};
        btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], bus.btn_n};
    end

    // A new level is taken only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        deb_cnt_d    = 16'd0;
        btn_st_d     = btn_st_q;
        press_acc    = 1'b0;
        btn_st_dly_d = btn_st_q;
        btn_evt_d    = btn_st_dly_q & ~btn_st_q;
        if (btn_s != btn_st_q) begin
            if (deb_cnt_q == DEB_CYCLES - 16'd1) begin
                btn_st_d  = btn_s;
                press_acc = ~btn_s;
            end else begin
                deb_cnt_d = deb_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_RESET: begin
                state_d    = S_WAIT_LOCK;
                hold_cnt_d = 8'd0;
            end
            S_WAIT_LOCK: begin
                hold_cnt_d = 8'd0;
                if (lock_s) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!lock_s) begin
                    state_d    = S_WAIT_LOCK;
                    hold_cnt_d = 8'd0;
                end else if (hold_cnt_q == HOLD_CYCLES - 8'd1) begin
                    state_d    = S_RUN;
                    hold_cnt_d = 8'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            S_RUN: begin
                // Lock loss wins over a simultaneous press.
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (press_acc) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d    = S_RESET;
                hold_cnt_d = 8'd0;
            end
        endcase
        rst_core_d = (state_d != S_RUN);
        run_d      = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_sync_q  <= '0;
            btn_sync_q   <= '1;
            deb_cnt_q    <= 16'd0;
            btn_st_q     <= 1'b1;
            btn_st_dly_q <= 1'b1;
            btn_evt_q    <= 1'b0;
            hold_cnt_q   <= 8'd0;
            state_q      <= S_RESET;
            rst_core_q   <= 1'b1;
            run_q        <= 1'b0;
        end else begin
            lock_sync_q  <= lock_sync_d;
            btn_sync_q   <= btn_sync_d;
            deb_cnt_q    <= deb_cnt_d;
            btn_st_q     <= btn_st_d;
            btn_st_dly_q <= btn_st_dly_d;
            btn_evt_q    <= btn_evt_d;
            hold_cnt_q   <= hold_cnt_d;
            state_q      <= state_d;
            rst_core_q   <= rst_core_d;
            run_q        <= run_d;
        end
    end

    assign bus.rst_core = rst_core_q;
    assign bus.run      = run_q;
    assign bus.btn_evt  = btn_evt_q;

endmodule
